// File: rtl/traffic_light_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_light_ctrl_if : request inputs and lamp/status outputs of the
//                         intersection controller.  Rev 1.0
// ---------------------------------------------------------------------------
interface traffic_light_ctrl_if;
  logic       ped_req;
  logic       flash_en;
  logic       ns_red;
  logic       ns_yellow;
  logic       ns_green;
  logic       ew_red;
  logic       ew_yellow;
  logic       ew_green;
  logic       walk;
  logic       ped_ack;
  logic [2:0] state;

  modport master (
    input  ped_req, flash_en,
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    output walk, ped_ack, state
  );

  modport slave (
    output ped_req, flash_en,
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    input  walk, ped_ack, state
  );
endinterface
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_light_ctrl : two-approach intersection controller with all-red
//                      clearance, latched pedestrian phase, night flash.  Rev 1.0
// ---------------------------------------------------------------------------
module traffic_light_ctrl #(
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 5,
  parameter int ALLRED_CYCLES = 2,
  parameter int PED_CYCLES    = 10,
  parameter int FLASH_HALF    = 4,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  traffic_light_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_ALLRED = 3'd0,
    ST_NS_G   = 3'd1,
    ST_NS_Y   = 3'd2,
    ST_EW_G   = 3'd3,
    ST_EW_Y   = 3'd4,
    ST_PED    = 3'd5,
    ST_FLASH  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_HALF - 1);

  // next_dir encoding: 0 = NS gets the next green, 1 = EW
  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_timer, w_timer;
  logic             r_next_dir, w_next_dir;
  logic             r_ped_pending, w_ped_pending;
  logic             r_flash_ph, w_flash_ph;
  logic             w_timer_zero;
  logic             w_entry;

  function automatic logic [CNT_W-1:0] load_of(input state_t s);
    case (s)
      ST_NS_G, ST_EW_G: load_of = GREEN_LD;
      ST_NS_Y, ST_EW_Y: load_of = YELLOW_LD;
      ST_PED:           load_of = PED_LD;
      ST_FLASH:         load_of = FLASH_LD;
      default:          load_of = ALLRED_LD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_ALLRED;
      r_timer       <= ALLRED_LD;
      r_next_dir    <= 1'b0;
      r_ped_pending <= 1'b0;
      r_flash_ph    <= 1'b1;
    end else begin
      r_state       <= w_state;
      r_timer       <= w_timer;
      r_next_dir    <= w_next_dir;
      r_ped_pending <= w_ped_pending;
      r_flash_ph    <= w_flash_ph;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_next_dir   = r_next_dir;
    w_timer_zero = (r_timer == '0);

    case (r_state)
      ST_ALLRED: if (w_timer_zero) begin
        if (bus.flash_en)       w_state = ST_FLASH;
        else if (r_ped_pending) w_state = ST_PED;
        else                    w_state = r_next_dir ? ST_EW_G : ST_NS_G;
      end
      // flash request cuts green short but always passes through yellow
      ST_NS_G: if (bus.flash_en || w_timer_zero) w_state = ST_NS_Y;
      ST_EW_G: if (bus.flash_en || w_timer_zero) w_state = ST_EW_Y;
      ST_NS_Y, ST_EW_Y: if (w_timer_zero) begin
        w_state    = ST_ALLRED;
        w_next_dir = ~r_next_dir;
      end
      ST_PED: if (w_timer_zero) w_state = r_next_dir ? ST_EW_G : ST_NS_G;
      ST_FLASH: if (!bus.flash_en) begin
        w_state    = ST_ALLRED;
        w_next_dir = 1'b0;
      end
      default: w_state = ST_ALLRED;
    endcase

    w_entry = (w_state != r_state);

    // FLASH is the only state that stays put at timer zero: it reloads the half-period
    if (w_entry)           w_timer = load_of(w_state);
    else if (w_timer_zero) w_timer = FLASH_LD;
    else                   w_timer = r_timer - CNT_W'(1);

    if (w_entry && w_state == ST_FLASH)            w_flash_ph = 1'b1;
    else if (r_state == ST_FLASH && w_timer_zero)  w_flash_ph = ~r_flash_ph;
    else                                           w_flash_ph = r_flash_ph;

    if (w_entry && (w_state == ST_PED || w_state == ST_FLASH))
      w_ped_pending = 1'b0;
    else if (bus.ped_req && r_state != ST_PED && r_state != ST_FLASH)
      w_ped_pending = 1'b1;
    else
      w_ped_pending = r_ped_pending;
  end

  always_comb begin
    bus.ns_red    = 1'b0;
    bus.ns_yellow = 1'b0;
    bus.ns_green  = 1'b0;
    bus.ew_red    = 1'b0;
    bus.ew_yellow = 1'b0;
    bus.ew_green  = 1'b0;
    bus.walk      = 1'b0;
    case (r_state)
      ST_NS_G: begin bus.ns_green  = 1'b1; bus.ew_red = 1'b1; end
      ST_NS_Y: begin bus.ns_yellow = 1'b1; bus.ew_red = 1'b1; end
      ST_EW_G: begin bus.ew_green  = 1'b1; bus.ns_red = 1'b1; end
      ST_EW_Y: begin bus.ew_yellow = 1'b1; bus.ns_red = 1'b1; end
      ST_PED: begin
        bus.ns_red = 1'b1;
        bus.ew_red = 1'b1;
        bus.walk   = 1'b1;
      end
      ST_FLASH: begin
        bus.ns_yellow = r_flash_ph;
        bus.ew_yellow = r_flash_ph;
      end
      default: begin bus.ns_red = 1'b1; bus.ew_red = 1'b1; end
    endcase
  end

  assign bus.ped_ack = r_ped_pending;
  assign bus.state   = r_state;

endmodule
`default_nettype wire
